// File: rtl/cnt_pkg.sv
// Shared constants and helpers for the parametrised up/down counter family.
package cnt_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// Enabled-cycle prescaler: step pulses combinationally on the last of every PRESCALE enabled cycles.
// State updates one cycle later; no backpressure, holds while en=0, sync_clr restarts the period.
module cnt_prescaler
  import cnt_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync_clr,
  output logic step
);

  localparam int PS_W = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [PS_W-1:0] TERM = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0] ONE  = PS_W'(1);

  logic [PS_W-1:0] pre_cnt;

  assign step = en && (pre_cnt == TERM);

  always_ff @(posedge clk) begin
    if (rst || sync_clr) begin
      pre_cnt <= '0;
    end else if (en) begin
      pre_cnt <= step ? '0 : pre_cnt + ONE;
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// Up/down counter with load, wrap/saturate limits, terminal-count pulse and sticky overflow.
// All outputs registered, one-cycle input-to-output latency; no backpressure.
module param_updown_counter
  import cnt_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat_mode,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("param_updown_counter: WIDTH must be >= 1");
    end
    if (MAX_VAL < 0 || MAX_VAL > 2**WIDTH - 1) begin : g_bad_max
      $error("param_updown_counter: MAX_VAL out of range for WIDTH");
    end
    if (PRESCALE < 1) begin : g_bad_ps
      $error("param_updown_counter: PRESCALE must be >= 1");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic             step;
  logic             boundary;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] ld_clamp;

  cnt_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync_clr (load),
    .step     (step)
  );

  // Limit test happens before +/-1 so the arithmetic never needs a carry-out.
  always_comb begin
    boundary = 1'b0;
    cnt_nxt  = count;
    ld_clamp = (load_val > MAX_C) ? MAX_C : load_val;
    if (dir == DIR_UP) begin
      boundary = (count == MAX_C);
      if (!boundary)                cnt_nxt = count + ONE;
      else if (sat_mode == MODE_WRAP) cnt_nxt = '0;
    end else begin
      boundary = (count == '0);
      if (!boundary)                cnt_nxt = count - ONE;
      else if (sat_mode == MODE_WRAP) cnt_nxt = MAX_C;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= ld_clamp;
      tc    <= 1'b0;
    end else begin
      tc <= step && boundary;
      if (step) count <= cnt_nxt;
      if (step && boundary) ovf <= 1'b1;
      else if (clr_ovf)     ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench: three counter configurations share stimulus; expectations queued at drive time.
module tb_param_updown_counter;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       dir = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       sat_mode = 1'b0;
  logic       clr_ovf = 1'b0;

  logic [3:0] cnt_o [N];
  logic       tc_o  [N];
  logic       ovf_o [N];

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [3:0] c;
    logic       t;
    logic       o;
  } exp_t;
  typedef exp_t [N-1:0] exp3_t;

  exp3_t sb[$];
  exp3_t e_mon;

  // Reference model state per instance: {default, MAX_VAL=9, PRESCALE=3}
  int maxv [N] = '{15, 9, 15};
  int ps   [N] = '{1, 1, 3};
  int mcnt [N];
  int mpre [N];
  bit mtc  [N];
  bit movf [N];

  always #5 clk = ~clk;

  param_updown_counter u_def (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .sat_mode(sat_mode), .clr_ovf(clr_ovf), .count(cnt_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0])
  );

  param_updown_counter #(.WIDTH(4), .MAX_VAL(9)) u_m9 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .sat_mode(sat_mode), .clr_ovf(clr_ovf), .count(cnt_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1])
  );

  param_updown_counter #(.WIDTH(4), .PRESCALE(3)) u_ps3 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .sat_mode(sat_mode), .clr_ovf(clr_ovf), .count(cnt_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    bit stp, bnd;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        mcnt[i] = 0; mpre[i] = 0; mtc[i] = 0; movf[i] = 0;
      end else if (load) begin
        mcnt[i] = (int'(load_val) > maxv[i]) ? maxv[i] : int'(load_val);
        mpre[i] = 0;
        mtc[i]  = 0;
      end else begin
        stp = en && (mpre[i] == ps[i] - 1);
        if (en) mpre[i] = stp ? 0 : mpre[i] + 1;
        bnd = dir ? (mcnt[i] == maxv[i]) : (mcnt[i] == 0);
        if (stp) begin
          if (!bnd)          mcnt[i] = dir ? mcnt[i] + 1 : mcnt[i] - 1;
          else if (!sat_mode) mcnt[i] = dir ? 0 : maxv[i];
        end
        mtc[i] = stp && bnd;
        if (stp && bnd)   movf[i] = 1;
        else if (clr_ovf) movf[i] = 0;
      end
    end
  endtask

  // Applies one cycle of inputs, queues the expected post-edge outputs, returns at posedge+2.
  task automatic drive(input bit r, input bit e, input bit d, input bit ld,
                       input logic [3:0] lv, input bit s, input bit c);
    exp3_t x;
    rst = r; en = e; dir = d; load = ld; load_val = lv; sat_mode = s; clr_ovf = c;
    model_update();
    for (int i = 0; i < N; i++) x[i] = '{c: 4'(mcnt[i]), t: mtc[i], o: movf[i]};
    sb.push_back(x);
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e_mon = sb.pop_front();
      for (int i = 0; i < N; i++) begin
        chk($sformatf("count[%0d]", i), 32'(cnt_o[i]), 32'(e_mon[i].c));
        chk($sformatf("tc[%0d]", i),    32'(tc_o[i]),  32'(e_mon[i].t));
        chk($sformatf("ovf[%0d]", i),   32'(ovf_o[i]), 32'(e_mon[i].o));
      end
    end
  end

  initial begin
    // reset
    drive(1, 0, 1, 0, 0, 0, 0);
    drive(1, 1, 1, 1, 4'd5, 0, 0);
    chk("rst_count", 32'(cnt_o[0]), 0);

    // 1: legacy up-count 0..15 and wrap
    for (int k = 0; k < 17; k++) drive(0, 1, 1, 0, 0, 0, 0);
    chk("t1_count", 32'(cnt_o[0]), 1);
    chk("t1_ovf", 32'(ovf_o[0]), 1);

    // 2: down-count with wrap at MAX_VAL=9
    drive(0, 0, 0, 1, 4'd2, 0, 0);
    for (int k = 0; k < 4; k++) drive(0, 1, 0, 0, 0, 0, 0);
    chk("t2_count_m9", 32'(cnt_o[1]), 8);
    chk("t2_count_def", 32'(cnt_o[0]), 14);

    // 3: saturation, then clr_ovf with and without a coinciding event
    drive(0, 0, 1, 1, 4'd14, 1, 0);
    for (int k = 0; k < 4; k++) drive(0, 1, 1, 0, 0, 1, 0);
    chk("t3_sat_tc", 32'(tc_o[0]), 1);
    drive(0, 0, 1, 0, 0, 1, 1);
    chk("t3_clr_ovf", 32'(ovf_o[0]), 0);
    drive(0, 1, 1, 0, 0, 1, 1);
    chk("t3_clr_vs_set", 32'(ovf_o[0]), 1);

    // 4: prescale, en gaps and mid-period load
    drive(1, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) drive(0, 1, 1, 0, 0, 0, 0);
    chk("t4_ps3_count", 32'(cnt_o[2]), 2);
    drive(0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) drive(0, 1, 1, 0, 0, 0, 0);
    chk("t4_ps3_stretch", 32'(cnt_o[2]), 3);
    drive(0, 1, 1, 1, 4'd0, 0, 0);
    for (int k = 0; k < 2; k++) drive(0, 1, 1, 0, 0, 0, 0);
    chk("t4_ps3_hold", 32'(cnt_o[2]), 0);
    drive(0, 1, 1, 0, 0, 0, 0);
    chk("t4_ps3_after_load", 32'(cnt_o[2]), 1);

    // 5: clamped load, load beats step
    drive(0, 1, 1, 1, 4'd12, 0, 0);
    chk("t5_clamp", 32'(cnt_o[1]), 9);
    chk("t5_no_step", 32'(cnt_o[0]), 12);

    // 6: reset mid-count with ovf set
    drive(0, 0, 1, 1, 4'd15, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 4'd7, 0, 0);
    chk("t6_pre_cnt", 32'(cnt_o[0]), 7);
    chk("t6_pre_ovf", 32'(ovf_o[0]), 1);
    drive(1, 1, 1, 0, 0, 0, 0);
    chk("t6_rst_ovf", 32'(ovf_o[0]), 0);
    for (int k = 0; k < 3; k++) drive(0, 1, 1, 0, 0, 0, 0);
    chk("t6_resume", 32'(cnt_o[0]), 3);

    // random mix across all controls
    for (int k = 0; k < 300; k++) begin
      drive(($urandom % 60) == 0, ($urandom % 4) != 0, 1'($urandom), ($urandom % 10) == 0,
            4'($urandom), ($urandom % 3) == 0, ($urandom % 8) == 0);
    end

    @(posedge clk);
    #2;
    chk("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
